nonce_dispatcher: RTL and testbench

Work scheduler between the host-facing UART link and an array of hash cores, all in the hash clock domain. On each new job it splits the `nonce_min..nonce_max` range into fixed-size chunks and hands them to idle cores with round-robin arbitration. It collects golden nonces from all cores and serialises them into the single `golden_nonce` / `new_golden_nonce` toggle pair consumed by the UART communication block.

---
 rtl/nonce_dispatcher.sv | 222 ++++++++++++++++++++++
 tb/tb_nonce_dispatcher.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: splits a nonce range into chunks for the hash cores and
// serialises their golden nonces onto the single UART-facing toggle pair.
module nonce_dispatcher #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned CHUNK_BITS = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 4096
) (
    input  logic                    hash_clk,
    input  logic                    reset,
    input  logic                    new_work,
    input  logic [31:0]             nonce_min,
    input  logic [31:0]             nonce_max,
    input  logic [NUM_CORES-1:0]    core_req,
    output logic [NUM_CORES-1:0]    core_grant,
    output logic [31:0]             chunk_start,
    output logic [31:0]             chunk_end,
    output logic                    core_abort,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    output logic [31:0]             golden_nonce,
    output logic                    new_golden_nonce,
    output logic                    range_done,
    output logic                    busy,
    output logic [7:0]              drop_count
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned FAW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [32:0]      CHUNK_M1 = (33'd1 << CHUNK_BITS) - 33'd1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [FAW-1:0]   LAST_PTR = FAW'(FIFO_DEPTH - 1);
    // The pop cycle itself counts as one gap cycle, so the counter reloads one short.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [32:0]          base_q, base_d, span_end;
    logic [31:0]          max_q, max_d, start_d, end_d;
    logic [IDX_W-1:0]     rr_q, rr_d, gidx, cand;
    logic [NUM_CORES-1:0] grant_d, req_m;
    logic                 hit, abort_d;

    logic [NUM_CORES-1:0] slot_valid, slot_valid_d, slot_load;
    logic [31:0]          slot_data [NUM_CORES];
    logic [IDX_W-1:0]     sptr_q, sel_idx, cand_s;
    logic                 sel_hit, move, pop, fifo_full;
    logic [31:0]          fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;
    logic [GAP_W-1:0]     gap_q;
    logic [4:0]           drops;
    logic [8:0]           drop_sum;
    logic [7:0]           drop_d;

    // Dispatch FSM: round-robin chunk grants, drain, done; new_work overrides all.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        max_d   = max_q;
        rr_d    = rr_q;
        grant_d = '0;
        start_d = chunk_start;
        end_d   = chunk_end;
        abort_d = 1'b0;
        req_m   = core_req & ~core_grant;
        hit     = 1'b0;
        gidx    = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            cand = IDX_W'((32'(rr_q) + i) % NUM_CORES);
            if (!hit && req_m[cand]) begin
                hit  = 1'b1;
                gidx = cand;
            end
        end
        span_end = base_q + CHUNK_M1;
        if (span_end > {1'b0, max_q}) begin
            span_end = {1'b0, max_q};
        end
        case (state_q)
            DISPATCH: begin
                if (hit) begin
                    grant_d = NUM_CORES'(1) << gidx;
                    start_d = base_q[31:0];
                    end_d   = span_end[31:0];
                    base_d  = span_end + 33'd1;
                    rr_d    = (gidx == LAST_IDX) ? '0 : gidx + IDX_W'(1);
                    if (span_end[31:0] == max_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last granted core still shows req in its grant cycle.
                if ((&core_req) && (core_grant == '0)) begin
                    state_d = DONE;
                end
            end
            default: ;
        endcase
        if (new_work) begin
            abort_d = 1'b1;
            grant_d = '0;
            start_d = chunk_start;
            end_d   = chunk_end;
            rr_d    = rr_q;
            base_d  = {1'b0, nonce_min};
            max_d   = nonce_max;
            state_d = (nonce_min > nonce_max) ? DONE : DISPATCH;
        end
    end

    // Dispatch state and registered dispatch outputs.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            max_q       <= '0;
            rr_q        <= '0;
            core_grant  <= '0;
            chunk_start <= '0;
            chunk_end   <= '0;
            core_abort  <= 1'b0;
            busy        <= 1'b0;
            range_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            max_q       <= max_d;
            rr_q        <= rr_d;
            core_grant  <= grant_d;
            chunk_start <= start_d;
            chunk_end   <= end_d;
            core_abort  <= abort_d;
            busy        <= (state_d == DISPATCH) || (state_d == DRAIN);
            range_done  <= (state_d == DONE);
        end
    end

    // Golden path: slot arbitration, slot refill/drop, FIFO pop pacing.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        cand_s  = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            cand_s = IDX_W'((32'(sptr_q) + i) % NUM_CORES);
            if (!sel_hit && slot_valid[cand_s]) begin
                sel_hit = 1'b1;
                sel_idx = cand_s;
            end
        end
        fifo_full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        move         = sel_hit && !fifo_full;
        pop          = (fifo_cnt != '0) && (gap_q == '0);
        slot_valid_d = slot_valid;
        slot_load    = '0;
        drops        = '0;
        if (move) begin
            slot_valid_d[sel_idx] = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (core_found[i]) begin
                if (slot_valid_d[i]) begin
                    drops = drops + 5'd1;
                end else begin
                    slot_valid_d[i] = 1'b1;
                    slot_load[i]    = 1'b1;
                end
            end
        end
        drop_sum = 9'(drop_count) + 9'(drops);
        drop_d   = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end

    // Golden path control registers and emitted nonce.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            slot_valid       <= '0;
            sptr_q           <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_cnt         <= '0;
            gap_q            <= '0;
            golden_nonce     <= '0;
            new_golden_nonce <= 1'b0;
            drop_count       <= '0;
        end else begin
            slot_valid <= slot_valid_d;
            drop_count <= drop_d;
            if (move) begin
                sptr_q <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + FAW'(1);
            end
            if (pop) begin
                rd_ptr           <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + FAW'(1);
                golden_nonce     <= fifo_mem[rd_ptr];
                new_golden_nonce <= ~new_golden_nonce;
                gap_q            <= GAP_LOAD;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(move) - CNT_W'(pop);
        end
    end

    // Slot and FIFO storage; validity is tracked separately so no reset needed.
    always_ff @(posedge hash_clk) begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (slot_load[i]) begin
                slot_data[i] <= core_nonce[32*i +: 32];
            end
        end
        if (move) begin
            fifo_mem[wr_ptr] <= slot_data[sel_idx];
        end
    end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher: 4 cores, 64K chunks, 4-deep FIFO, gap 8.
module tb_nonce_dispatcher;

    logic         clk = 1'b0;
    logic         reset;
    logic         new_work;
    logic [31:0]  nonce_min;
    logic [31:0]  nonce_max;
    logic [3:0]   core_req;
    logic [3:0]   core_grant;
    logic [31:0]  chunk_start;
    logic [31:0]  chunk_end;
    logic         core_abort;
    logic [3:0]   core_found;
    logic [127:0] core_nonce;
    logic [31:0]  golden_nonce;
    logic         new_golden_nonce;
    logic         range_done;
    logic         busy;
    logic [7:0]   drop_count;

    int   checks   = 0;
    int   failures = 0;
    logic exp_tog  = 1'b0;

    always #5 clk = ~clk;

    nonce_dispatcher #(
        .NUM_CORES (4),
        .CHUNK_BITS(16),
        .FIFO_DEPTH(4),
        .GAP_CYCLES(8)
    ) dut (
        .hash_clk        (clk),
        .reset           (reset),
        .new_work        (new_work),
        .nonce_min       (nonce_min),
        .nonce_max       (nonce_max),
        .core_req        (core_req),
        .core_grant      (core_grant),
        .chunk_start     (chunk_start),
        .chunk_end       (chunk_end),
        .core_abort      (core_abort),
        .core_found      (core_found),
        .core_nonce      (core_nonce),
        .golden_nonce    (golden_nonce),
        .new_golden_nonce(new_golden_nonce),
        .range_done      (range_done),
        .busy            (busy),
        .drop_count      (drop_count)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check a grant visible now, then the granted core drops its request.
    task automatic exp_grant(input logic [1:0] idx, input logic [31:0] s, input logic [31:0] e);
        chk("grant", 32'(core_grant), 32'(1) << idx);
        chk("chunk_start", chunk_start, s);
        chk("chunk_end", chunk_end, e);
        core_req[idx] = 1'b0;
    endtask

    task automatic exp_golden(input logic [31:0] n);
        exp_tog = ~exp_tog;
        chk("golden_nonce", golden_nonce, n);
        chk("new_golden_nonce", 32'(new_golden_nonce), 32'(exp_tog));
    endtask

    // Pulse new_work for one cycle; returns on the following negedge.
    task automatic start_job(input logic [31:0] lo, input logic [31:0] hi);
        new_work  = 1'b1;
        nonce_min = lo;
        nonce_max = hi;
        tick(1);
        new_work  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        new_work   = 1'b0;
        nonce_min  = '0;
        nonce_max  = '0;
        core_req   = '0;
        core_found = '0;
        core_nonce = '0;
        tick(2);
        chk("rst_grant", 32'(core_grant), 32'h0);
        chk("rst_start", chunk_start, 32'h0);
        chk("rst_abort", 32'(core_abort), 32'h0);
        chk("rst_golden", golden_nonce, 32'h0);
        chk("rst_tog", 32'(new_golden_nonce), 32'h0);
        chk("rst_done", 32'(range_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        reset = 1'b0;
        tick(2);

        // Basic split: three 64K chunks to cores 0,1,2
        core_req = 4'hF;
        start_job(32'h0, 32'h2FFFF);
        chk("split_abort", 32'(core_abort), 32'h1);
        chk("split_nogrant", 32'(core_grant), 32'h0);
        chk("split_busy", 32'(busy), 32'h1);
        tick(1);
        exp_grant(2'd0, 32'h0, 32'hFFFF);
        tick(1);
        exp_grant(2'd1, 32'h10000, 32'h1FFFF);
        tick(1);
        exp_grant(2'd2, 32'h20000, 32'h2FFFF);
        tick(1);
        chk("drain_grant", 32'(core_grant), 32'h0);
        chk("drain_busy", 32'(busy), 32'h1);
        chk("drain_notdone", 32'(range_done), 32'h0);
        core_req = 4'hF;
        tick(1);
        chk("split_done", 32'(range_done), 32'h1);
        chk("split_idle", 32'(busy), 32'h0);

        // Clipping: one short chunk, RR pointer now at core 3
        start_job(32'h10, 32'h15);
        chk("clip_abort", 32'(core_abort), 32'h1);
        chk("clip_done_clr", 32'(range_done), 32'h0);
        tick(1);
        exp_grant(2'd3, 32'h10, 32'h15);
        tick(1);
        chk("clip_drain", 32'(core_grant), 32'h0);
        chk("clip_busy", 32'(busy), 32'h1);
        chk("clip_abort_end", 32'(core_abort), 32'h0);
        core_req = 4'hF;
        tick(1);
        chk("clip_done", 32'(range_done), 32'h1);

        // Empty range: straight to done, chunk registers held
        start_job(32'h5, 32'h4);
        chk("empty_abort", 32'(core_abort), 32'h1);
        chk("empty_done", 32'(range_done), 32'h1);
        chk("empty_busy", 32'(busy), 32'h0);
        chk("empty_grant", 32'(core_grant), 32'h0);
        tick(1);
        chk("empty_grant2", 32'(core_grant), 32'h0);
        chk("empty_held", chunk_start, 32'h10);

        // Top of space: single chunk ending at FFFFFFFF, no wrap
        start_job(32'hFFFF0000, 32'hFFFFFFFF);
        tick(1);
        exp_grant(2'd0, 32'hFFFF0000, 32'hFFFFFFFF);
        tick(1);
        chk("top_nowrap1", 32'(core_grant), 32'h0);
        chk("top_busy", 32'(busy), 32'h1);
        tick(1);
        chk("top_nowrap2", 32'(core_grant), 32'h0);
        core_req = 4'hF;
        tick(1);
        chk("top_done", 32'(range_done), 32'h1);
        chk("top_nowrap3", 32'(core_grant), 32'h0);

        // Simultaneous finds: emitted A,B,C,D exactly 8 cycles apart
        core_found = 4'hF;
        core_nonce = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        tick(1);
        core_found = '0;
        chk("find_tog_t1", 32'(new_golden_nonce), 32'h0);
        tick(1);
        chk("find_tog_t2", 32'(new_golden_nonce), 32'h0);
        tick(1);
        exp_golden(32'hAAAA0000);
        tick(7);
        chk("gap_hold_a", 32'(new_golden_nonce), 32'(exp_tog));
        tick(1);
        exp_golden(32'hBBBB0001);
        tick(8);
        exp_golden(32'hCCCC0002);
        tick(7);
        chk("gap_hold_c", golden_nonce, 32'hCCCC0002);
        tick(1);
        exp_golden(32'hDDDD0003);
        chk("find_nodrop", 32'(drop_count), 32'h0);

        // Core 1 finds twice in a row while slot 0 wins the move: one drop
        tick(10);
        core_found = 4'b0011;
        core_nonce = {32'h0, 32'h0, 32'h11110001, 32'h0000000F};
        tick(1);
        core_found = 4'b0010;
        core_nonce = {32'h0, 32'h0, 32'h22220002, 32'h0};
        tick(1);
        core_found = '0;
        chk("drop_one", 32'(drop_count), 32'h1);
        tick(1);
        exp_golden(32'h0000000F);
        tick(8);
        exp_golden(32'h11110001);
        tick(10);
        chk("dropped_absent", golden_nonce, 32'h11110001);
        chk("dropped_notog", 32'(new_golden_nonce), 32'(exp_tog));
        chk("drop_still_one", 32'(drop_count), 32'h1);

        // Abort mid-dispatch with a golden nonce left in the FIFO
        core_req   = 4'hF;
        core_found = 4'b1001;
        core_nonce = {32'h0BAD0003, 32'h0, 32'h0, 32'h0BAD0000};
        start_job(32'h0, 32'hFFFFF);
        core_found = '0;
        chk("job_abort", 32'(core_abort), 32'h1);
        chk("job_done_clr", 32'(range_done), 32'h0);
        tick(1);
        exp_grant(2'd1, 32'h0, 32'hFFFF);
        tick(1);
        exp_grant(2'd2, 32'h10000, 32'h1FFFF);
        exp_golden(32'h0BAD0003);
        start_job(32'h100000, 32'h1FFFFF);
        chk("abort_pulse", 32'(core_abort), 32'h1);
        chk("abort_nogrant", 32'(core_grant), 32'h0);
        chk("abort_busy", 32'(busy), 32'h1);
        chk("abort_done_clr", 32'(range_done), 32'h0);
        core_req = 4'hF;
        tick(1);
        exp_grant(2'd3, 32'h100000, 32'h10FFFF);
        core_req = '0;
        tick(5);
        chk("fifo_wait", 32'(new_golden_nonce), 32'(exp_tog));
        tick(1);
        exp_golden(32'h0BAD0000);

        // Asynchronous reset with a nonce in flight, no toggle on release
        core_found = 4'b0100;
        core_nonce = {32'h0, 32'h5EED0002, 32'h0, 32'h0};
        tick(1);
        core_found = '0;
        tick(2);
        #1 reset = 1'b1;
        #1;
        chk("arst_tog", 32'(new_golden_nonce), 32'h0);
        chk("arst_golden", golden_nonce, 32'h0);
        chk("arst_start", chunk_start, 32'h0);
        chk("arst_end", chunk_end, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_drop", 32'(drop_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(12);
        chk("post_rst_tog", 32'(new_golden_nonce), 32'h0);
        chk("post_rst_golden", golden_nonce, 32'h0);
        chk("post_rst_grant", 32'(core_grant), 32'h0);
        chk("post_rst_done", 32'(range_done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
